cdc_src_clear_seq: RTL and testbench

Source-domain companion placed directly upstream of the clearable 2-phase CDC source port. It forwards a valid/ready stream through a one-entry register stage and sequences software clear requests into the CDC. The sequence is: drain or flush, then a single-cycle clear pulse, then wait for the CDC's clear-pending to rise and fall, then signal done. It guarantees the CDC rules "valid low while clear asserted" and "no clear while clear pending".

---
 rtl/cdc_src_clear_seq_pkg.sv | 17 +
 rtl/cdc_src_clear_seq_buf.sv | 53 +++++
 rtl/cdc_src_clear_seq.sv | 161 ++++++++++++++++
 tb/tb_cdc_src_clear_seq.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cdc_src_clear_seq_pkg.sv
// Shared types for the CDC source-side clear sequencer.
//   state_e    : sequencer FSM states (3-bit encoding)
//   DROP_CNT_W : width of the optional drop statistics counter
package cdc_src_clear_seq_pkg;

  localparam int unsigned DROP_CNT_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_REMOTE   = 3'd1,
    ST_DRAIN    = 3'd2,
    ST_CLEAR    = 3'd3,
    ST_WAIT_SET = 3'd4,
    ST_WAIT_CLR = 3'd5
  } state_e;

endpackage

// File: rtl/cdc_src_clear_seq_buf.sv
// One-entry valid/ready register stage with enables and flush.
// There is no combinational data path from input to output, so an accepted
// item appears on the output one cycle later. Push and pop may happen in
// the same cycle, giving 1 item/cycle throughput.
// Ports:
//   clk_i, rst_ni       clock, async active-low reset
//   in_en_i             allow accepting new items
//   out_en_i            allow presenting/popping the stored item
//   flush_i             discard the stored item (wins over push/pop)
//   data_i/valid_i/ready_o   upstream stream
//   data_o/valid_o/ready_i   downstream stream
//   full_o              entry occupied
module cdc_src_clear_seq_buf #(
  parameter type T = logic
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic in_en_i,
  input  logic out_en_i,
  input  logic flush_i,
  input  T     data_i,
  input  logic valid_i,
  output logic ready_o,
  output T     data_o,
  output logic valid_o,
  input  logic ready_i,
  output logic full_o
);

  logic full_q;
  T     data_q;
  logic push, pop;

  assign pop     = full_q & out_en_i & ready_i;
  assign ready_o = in_en_i & (~full_q | pop);
  assign push    = valid_i & ready_o;
  assign valid_o = full_q & out_en_i;
  assign data_o  = data_q;
  assign full_o  = full_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)      full_q <= 1'b0;
    else if (flush_i) full_q <= 1'b0;
    else if (push)    full_q <= 1'b1;
    else if (pop)     full_q <= 1'b0;
  end

  // Payload register carries no reset; full_q qualifies it.
  always_ff @(posedge clk_i) begin
    if (push) data_q <= data_i;
  end

endmodule

// File: rtl/cdc_src_clear_seq.sv
// Source-domain clear sequencer sitting directly upstream of a clearable
// 2-phase CDC source port. Forwards a valid/ready stream through a one-entry
// register and turns software clear requests into: drain (or flush on
// timeout), one-cycle clear pulse, wait for clear-pending to rise and fall,
// done pulse. A remote clear (pending seen in IDLE) parks the stream until
// pending falls.
// Optional feature macro: CDC_SRC_CLEAR_SEQ_STATS_EN adds drop_cnt_o, a
// saturating 16-bit count of drop_o pulses, reset only by rst_ni.
// Ports:
//   clk_i, rst_ni            clock, async active-low reset
//   clr_req_i                clear request pulse
//   clr_done_o               clear sequence finished pulse
//   busy_o                   sequencer not idle
//   drop_o                   buffered item discarded
//   data_i/valid_i/ready_o   upstream stream
//   cdc_data_o/cdc_valid_o/cdc_ready_i   stream to the CDC
//   cdc_clear_o              clear to the CDC
//   cdc_clear_pending_i      clear pending from the CDC
//   drop_cnt_o               (stats build only) drop counter
module cdc_src_clear_seq
  import cdc_src_clear_seq_pkg::*;
#(
  parameter type         T             = logic,
  parameter int unsigned DRAIN_TIMEOUT = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_req_i,
  output logic clr_done_o,
  output logic busy_o,
  output logic drop_o,
  input  T     data_i,
  input  logic valid_i,
  output logic ready_o,
  output T     cdc_data_o,
  output logic cdc_valid_o,
  input  logic cdc_ready_i,
  output logic cdc_clear_o,
  input  logic cdc_clear_pending_i
`ifdef CDC_SRC_CLEAR_SEQ_STATS_EN
  ,
  output logic [DROP_CNT_W-1:0] drop_cnt_o
`endif
);

  localparam int unsigned          CNT_W    = $clog2(DRAIN_TIMEOUT + 1);
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(DRAIN_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic             req_q, req_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             buf_en, out_en, flush, full;
  logic             pend;

  assign pend = cdc_clear_pending_i;

  cdc_src_clear_seq_buf #(.T(T)) u_buf (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .in_en_i  (buf_en),
    .out_en_i (out_en),
    .flush_i  (flush),
    .data_i   (data_i),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .data_o   (cdc_data_o),
    .valid_o  (cdc_valid_o),
    .ready_i  (cdc_ready_i),
    .full_o   (full)
  );

  // State, request latch and drain counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      req_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        // Remote clear beats a same-cycle local request.
        if (pend)                    state_d = ST_REMOTE;
        else if (req_q || clr_req_i) state_d = ST_DRAIN;
      end
      ST_REMOTE:   if (!pend) state_d = ST_IDLE;
      ST_DRAIN: begin
        // A remote clear arriving mid-drain serves our request too.
        if (pend)                         state_d = ST_WAIT_CLR;
        else if (!full || cdc_ready_i)    state_d = ST_CLEAR;
        else if (cnt_q == CNT_LAST)       state_d = ST_CLEAR;
      end
      ST_CLEAR:    state_d = ST_WAIT_SET;
      ST_WAIT_SET: if (pend)  state_d = ST_WAIT_CLR;
      ST_WAIT_CLR: if (!pend) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Outputs and datapath controls.
  always_comb begin
    buf_en      = 1'b0;
    out_en      = 1'b0;
    flush       = 1'b0;
    drop_o      = 1'b0;
    cdc_clear_o = 1'b0;
    clr_done_o  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Park the stream in the same cycle pending is first seen.
        buf_en = ~pend;
        out_en = ~pend;
      end
      ST_DRAIN: begin
        out_en = 1'b1;
        if (pend) begin
          flush  = 1'b1;
          drop_o = full & ~cdc_ready_i;
        end else if (full && !cdc_ready_i && cnt_q == CNT_LAST) begin
          flush  = 1'b1;
          drop_o = 1'b1;
        end
      end
      // Never clear on top of a pending clear; a remote clear racing in
      // here is simply followed through WAIT_SET/WAIT_CLR.
      ST_CLEAR:    cdc_clear_o = ~pend;
      ST_WAIT_CLR: clr_done_o  = ~pend;
      default: ;
    endcase
  end

  // Any exit from DRAIN services the latched request; a new request in the
  // same cycle still wins and is queued for the next sequence.
  always_comb begin
    req_d = clr_req_i |
            (req_q & ~((state_q == ST_DRAIN) && (state_d != ST_DRAIN)));
    cnt_d = '0;
    if (state_q == ST_DRAIN && state_d == ST_DRAIN && cnt_q != CNT_LAST)
      cnt_d = cnt_q + CNT_W'(1);
  end

  assign busy_o = (state_q != ST_IDLE);

`ifdef CDC_SRC_CLEAR_SEQ_STATS_EN
  logic [DROP_CNT_W-1:0] drop_cnt_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                         drop_cnt_q <= '0;
    else if (drop_o && drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + 1'b1;
  end
  assign drop_cnt_o = drop_cnt_q;
`endif

endmodule

// File: tb/tb_cdc_src_clear_seq.sv
module tb_cdc_src_clear_seq;

  logic       clk, rst_n;
  logic       clr_req, valid_i, cdc_ready, pending;
  logic [7:0] din;
  logic       clr_done, busy, drop, ready_o, cdc_valid, cdc_clear;
  logic [7:0] cdc_data;
`ifdef CDC_SRC_CLEAR_SEQ_STATS_EN
  logic [15:0] drop_cnt;
`endif

  int total = 0;
  int bad   = 0;
  int deliv = 0;
  int ndone = 0;
  int nclr  = 0;
  bit stream_chk = 0;
  logic [7:0] q[$];   // reference content of the one-entry stage

  cdc_src_clear_seq #(.T(logic [7:0]), .DRAIN_TIMEOUT(16)) dut (
    .clk_i               (clk),
    .rst_ni              (rst_n),
    .clr_req_i           (clr_req),
    .clr_done_o          (clr_done),
    .busy_o              (busy),
    .drop_o              (drop),
    .data_i              (din),
    .valid_i             (valid_i),
    .ready_o             (ready_o),
    .cdc_data_o          (cdc_data),
    .cdc_valid_o         (cdc_valid),
    .cdc_ready_i         (cdc_ready),
    .cdc_clear_o         (cdc_clear),
    .cdc_clear_pending_i (pending)
`ifdef CDC_SRC_CLEAR_SEQ_STATS_EN
    ,
    .drop_cnt_o          (drop_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sample point in the middle of the cycle: reference model bookkeeping.
  task automatic settle();
    #3;
    if (stream_chk) begin
      chk("s_valid", cdc_valid, q.size() != 0);
      chk("s_ready", ready_o, (q.size() == 0) || cdc_ready);
      if (q.size() != 0) chk("s_data", cdc_data, q[0]);
    end
    if (cdc_valid && cdc_ready) begin
      chk("pop_nonempty", q.size(), 1);
      if (q.size() != 0) begin
        chk("pop_data", cdc_data, q[0]);
        void'(q.pop_front());
      end
      deliv++;
    end
    if (drop) begin
      chk("drop_nonempty", q.size(), 1);
      if (q.size() != 0) void'(q.pop_front());
    end
    if (cdc_clear) begin
      nclr++;
      chk("clr_vs_valid", cdc_valid, 0);
      chk("clr_vs_pend", pending, 0);
    end
    if (clr_done) ndone++;
    if (valid_i && ready_o) begin
      q.push_back(din);
      chk("depth", q.size() <= 1, 1);
    end
  endtask

  task automatic drv(input logic v, input logic [7:0] d, input logic rdy,
                     input logic pnd, input logic req);
    valid_i = v; din = d; cdc_ready = rdy; pending = pnd; clr_req = req;
    settle();
  endtask

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  initial begin
    int d0, c0;
    rst_n = 1'b0; clr_req = 0; valid_i = 0; cdc_ready = 0; pending = 0; din = 0;
    repeat (2) @(posedge clk);
    #4;
    chk("rst_valid", cdc_valid, 0);
    chk("rst_clear", cdc_clear, 0);
    chk("rst_done", clr_done, 0);
    chk("rst_drop", drop, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", ready_o, 1);
`ifdef CDC_SRC_CLEAR_SEQ_STATS_EN
    chk("rst_dcnt", drop_cnt, 0);
`endif
    nxt();
    rst_n = 1'b1;

    // 8 back-to-back items, sink always ready
    stream_chk = 1;
    for (int i = 0; i < 8; i++) begin
      drv(1, 8'h10 + 8'(i), 1, 0, 0);
      chk("t1_ready", ready_o, 1);
      if (i > 0) chk("t1_lat", cdc_data, 8'h10 + 8'(i - 1));
      nxt();
    end
    drv(0, 0, 1, 0, 0); nxt();
    chk("t1_count", deliv, 8);

    // random stream with random backpressure
    for (int i = 0; i < 200; i++) begin
      drv(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), 0, 0);
      nxt();
    end
    drv(0, 0, 1, 0, 0); nxt();
    drv(0, 0, 1, 0, 0); nxt();
    chk("rand_empty", q.size(), 0);
    stream_chk = 0;

    // drain completes when sink becomes ready 3 cycles after the request
    drv(1, 8'hA5, 0, 0, 0); nxt();
    c0 = nclr; d0 = ndone;
    drv(0, 0, 0, 0, 1); chk("t2_idle", busy, 0); nxt();
    for (int k = 0; k < 2; k++) begin
      drv(1, 8'h5A, 0, 0, 0);
      chk("t2_rdy_blk", ready_o, 0);
      chk("t2_hold", cdc_valid, 1);
      chk("t2_busy", busy, 1);
      chk("t2_nodrop", drop, 0);
      nxt();
    end
    drv(0, 0, 1, 0, 0);
    chk("t2_deliver", cdc_data, 8'hA5);
    chk("t2_vld", cdc_valid, 1);
    chk("t2_nodrop2", drop, 0);
    nxt();
    drv(0, 0, 0, 0, 0); chk("t2_clr", cdc_clear, 1); chk("t2_clr_vld", cdc_valid, 0); nxt();
    for (int k = 0; k < 5; k++) begin
      drv(0, 0, 0, 1, 0); chk("t2_clr_off", cdc_clear, 0); chk("t2_nodone", clr_done, 0); nxt();
    end
    drv(0, 0, 0, 0, 0); chk("t2_done", clr_done, 1); nxt();
    drv(0, 0, 0, 0, 0); chk("t2_idle2", busy, 0); chk("t2_done1", clr_done, 0); nxt();
    chk("t2_nclr", nclr - c0, 1);
    chk("t2_ndone", ndone - d0, 1);

    // drain timeout: sink stalled, item flushed on the 16th drain cycle
    drv(1, 8'hB6, 0, 0, 0); nxt();
    drv(0, 0, 0, 0, 1); nxt();
    for (int k = 1; k <= 16; k++) begin
      drv(0, 0, 0, 0, 0); chk("t3_drop", drop, k == 16); nxt();
    end
    drv(0, 0, 0, 0, 0); chk("t3_clr", cdc_clear, 1); chk("t3_empty", q.size(), 0); nxt();
`ifdef CDC_SRC_CLEAR_SEQ_STATS_EN
    chk("t3_dcnt", drop_cnt, 1);
`endif
    drv(0, 0, 0, 1, 0); nxt();
    drv(0, 0, 0, 1, 0); nxt();
    drv(0, 0, 0, 0, 0); chk("t3_done", clr_done, 1); nxt();

    // remote clear while idle with an item buffered
    drv(1, 8'hC7, 0, 0, 0); nxt();
    c0 = nclr;
    for (int k = 0; k < 5; k++) begin
      drv(1, 8'h11, 1, 1, 0);
      chk("t4_rdy", ready_o, 0);
      chk("t4_vld", cdc_valid, 0);
      chk("t4_clr", cdc_clear, 0);
      nxt();
    end
    drv(0, 0, 1, 0, 0); chk("t4_vld_last", cdc_valid, 0); chk("t4_busy", busy, 1); nxt();
    drv(0, 0, 1, 0, 0);
    chk("t4_deliver", cdc_data, 8'hC7);
    chk("t4_vld2", cdc_valid, 1);
    chk("t4_idle", busy, 0);
    nxt();
    drv(0, 0, 1, 0, 0); chk("t4_gone", cdc_valid, 0); chk("t4_nclr", nclr - c0, 0); nxt();

    // request during WAIT_CLR is queued: two full sequences
    d0 = ndone; c0 = nclr;
    drv(0, 0, 0, 0, 1); nxt();
    drv(0, 0, 0, 0, 0); chk("t5_busy", busy, 1); nxt();
    drv(0, 0, 0, 0, 0); chk("t5_clr1", cdc_clear, 1); nxt();
    drv(0, 0, 0, 1, 0); nxt();
    drv(0, 0, 0, 1, 1); nxt();
    drv(0, 0, 0, 0, 0); chk("t5_done1", clr_done, 1); nxt();
    drv(0, 0, 0, 0, 0); chk("t5_gap", clr_done, 0); nxt();
    drv(0, 0, 0, 0, 0); chk("t5_busy2", busy, 1); nxt();
    drv(0, 0, 0, 0, 0); chk("t5_clr2", cdc_clear, 1); nxt();
    drv(0, 0, 0, 1, 0); nxt();
    drv(0, 0, 0, 0, 0); chk("t5_done2", clr_done, 1); nxt();
    for (int k = 0; k < 5; k++) begin
      drv(0, 0, 0, 0, 0); chk("t5_quiet", busy, 0); nxt();
    end
    chk("t5_ndone", ndone - d0, 2);
    chk("t5_nclr", nclr - c0, 2);

    // async reset while in WAIT_SET
    drv(0, 0, 0, 0, 1); nxt();
    drv(0, 0, 0, 0, 0); nxt();
    drv(0, 0, 0, 0, 0); nxt();
    drv(0, 0, 0, 0, 0);
    chk("t6_pre_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_busy", busy, 0);
    chk("t6_clear", cdc_clear, 0);
    chk("t6_valid", cdc_valid, 0);
    chk("t6_done", clr_done, 0);
    chk("t6_drop", drop, 0);
    chk("t6_ready", ready_o, 1);
    q.delete();
    nxt();
    rst_n = 1'b1;
    d0 = ndone;
    for (int k = 0; k < 10; k++) begin
      drv(0, 0, 0, (k == 1 || k == 2), 0); chk("t6_nodone", clr_done, 0); nxt();
    end
    chk("t6_ndone", ndone - d0, 0);
    chk("t6_idle", busy, 0);

    // remote clear racing a drain: flush, drop, done, request consumed
    drv(1, 8'hD8, 0, 0, 0); nxt();
    drv(0, 0, 0, 0, 1); nxt();
    drv(0, 0, 0, 1, 0); chk("t7_drop", drop, 1); nxt();
    drv(0, 0, 0, 0, 0); chk("t7_done", clr_done, 1); nxt();
    for (int k = 0; k < 4; k++) begin
      drv(0, 0, 0, 0, 0); chk("t7_idle", busy, 0); chk("t7_nodrop", drop, 0); nxt();
    end
    chk("t7_empty", q.size(), 0);
`ifdef CDC_SRC_CLEAR_SEQ_STATS_EN
    chk("t7_dcnt", drop_cnt, 2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
